ps2_frame_rx: RTL and testbench

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_filter.sv | 61 ++++++
 rtl/ps2_frame_rx.sv | 152 +++++++++++++++
 tb/tb_ps2_frame_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 frame receiver: FSM state encoding,
// well-known scan codes and the odd-parity helper.
package ps2_pkg;

    // Receiver FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Scan-code constants
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXTENDED = 8'hE0;
    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;

    // Odd parity holds when data bits plus parity bit XOR to 1
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the filtered output
// only follows the synchronized line after FILTER_LEN consecutive samples
// that differ from the current output. Everything resets to the PS/2 idle
// level (1).
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_i,
    output logic line_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Bring the asynchronous line into the clk domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

    // Count consecutive differing samples; flip the output on the last one
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync_q[1] != filt_q) begin
            if (cnt_q >= CNT_LAST) begin
                filt_d = sync_q[1];
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver. Filters kclk/kdata, samples data on
// filtered kclk falling edges, checks start/parity/stop, and shifts each
// valid byte into a two-byte keycode history. A stalled frame is abandoned
// after TIMEOUT_CYC cycles without a falling edge.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kclk,
    input  logic        kdata,
    output logic [15:0] keycode,
    output logic        oflag,
    output logic        perr
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    logic          kclk_f_s;
    logic          kdata_f_s;
    logic          fall_s;
    logic          kclk_prev_q;
    logic [1:0]    state_q,   state_d;
    logic [2:0]    bitcnt_q,  bitcnt_d;
    logic [7:0]    shift_q,   shift_d;
    logic          ferr_q,    ferr_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic [15:0]   keycode_q, keycode_d;
    logic          oflag_q,   oflag_d;
    logic          perr_q,    perr_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kclk_filt (
        .clk    (clk),
        .reset  (reset),
        .line_i (kclk),
        .line_o (kclk_f_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_kdata_filt (
        .clk    (clk),
        .reset  (reset),
        .line_i (kdata),
        .line_o (kdata_f_s)
    );

    assign fall_s = kclk_prev_q & ~kclk_f_s;

    // Next-state logic: frame parsing, timeout and output pulse generation
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
        tmo_d     = tmo_q;
        keycode_d = keycode_q;
        oflag_d   = 1'b0;
        perr_d    = 1'b0;

        if (state_q == ST_IDLE) begin
            tmo_d = '0;
            if (fall_s && !kdata_f_s) begin
                state_d  = ST_DATA;
                bitcnt_d = 3'd0;
                shift_d  = 8'h00;
                ferr_d   = 1'b0;
            end else begin
                state_d  = ST_IDLE;
            end
        end else if (fall_s) begin
            // Every edge inside a frame restarts the inactivity window
            tmo_d = '0;
            case (state_q)
                ST_DATA: begin
                    shift_d  = {kdata_f_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (!odd_parity_ok(shift_q, kdata_f_s)) begin
                        ferr_d = 1'b1;
                    end else begin
                        ferr_d = ferr_q;
                    end
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (kdata_f_s && !ferr_q) begin
                        keycode_d = {keycode_q[7:0], shift_q};
                        oflag_d   = 1'b1;
                    end else begin
                        perr_d    = 1'b1;
                    end
                    state_d  = ST_IDLE;
                    bitcnt_d = 3'd0;
                    shift_d  = 8'h00;
                    ferr_d   = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (tmo_q >= TMO_MAX) begin
            // Stalled frame: drop partial data and flag it
            state_d  = ST_IDLE;
            bitcnt_d = 3'd0;
            shift_d  = 8'h00;
            ferr_d   = 1'b0;
            tmo_d    = '0;
            perr_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kclk_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            ferr_q      <= 1'b0;
            tmo_q       <= '0;
            keycode_q   <= 16'h0000;
            oflag_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            kclk_prev_q <= kclk_f_s;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            ferr_q      <= ferr_d;
            tmo_q       <= tmo_d;
            keycode_q   <= keycode_d;
            oflag_q     <= oflag_d;
            perr_q      <= perr_d;
        end
    end

    assign keycode = keycode_q;
    assign oflag   = oflag_q;
    assign perr    = perr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed scenarios plus random
// frames compared against a frame-level reference model.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 30;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        kclk  = 1'b1;
    logic        kdata = 1'b1;
    logic [15:0] keycode;
    logic        oflag;
    logic        perr;

    int checks   = 0;
    int failures = 0;
    int n_of     = 0;
    int n_pe     = 0;
    int n_both   = 0;
    logic [15:0] exp_kc = 16'h0000;

    ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .kclk    (kclk),
        .kdata   (kdata),
        .keycode (keycode),
        .oflag   (oflag),
        .perr    (perr)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (oflag) n_of <= n_of + 1;
        if (perr) n_pe <= n_pe + 1;
        if (oflag && perr) n_both <= n_both + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive nb bits (LSB first), one kclk low pulse per bit
    task automatic send_bits(input logic [10:0] bits, input int nb);
        for (int i = 0; i < nb; i++) begin
            kdata = bits[i];
            wait_cyc(HALF);
            kclk = 1'b0;
            wait_cyc(HALF);
            kclk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Send one whole frame and compare against the reference model
    task automatic frame_and_check(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int of0;
        int pe0;
        bit ok;
        of0 = n_of;
        pe0 = n_pe;
        send_bits(mk_frame(b, bad_par, bad_stop), 11);
        kdata = 1'b1;
        wait_cyc(2);
        ok = !bad_par && !bad_stop;
        if (ok) exp_kc = {exp_kc[7:0], b};
        chk_eq({tag, " keycode"}, 32'(keycode), 32'(exp_kc));
        chk_eq({tag, " oflag"}, 32'(n_of - of0), 32'(ok));
        chk_eq({tag, " perr"}, 32'(n_pe - pe0), 32'(!ok));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int of0;
        int pe0;
        logic [7:0] b;
        int r;

        // Reset state while reset is held low
        wait_cyc(5);
        chk_eq("reset keycode", 32'(keycode), 32'h0);
        chk_eq("reset oflag", 32'(oflag), 32'h0);
        chk_eq("reset perr", 32'(perr), 32'h0);
        chk_eq("reset state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b1;
        wait_cyc(20);

        // Single valid frame, then a break/make pair
        frame_and_check("up", SC_UP, 1'b0, 1'b0);
        frame_and_check("break", SC_BREAK, 1'b0, 1'b0);
        frame_and_check("up2", SC_UP, 1'b0, 1'b0);

        // Parity error
        frame_and_check("left badpar", SC_LEFT, 1'b1, 1'b0);
        // Stop-bit error
        frame_and_check("ext badstop", SC_EXTENDED, 1'b0, 1'b1);

        // Short kclk glitch while idle must be ignored
        of0 = n_of;
        pe0 = n_pe;
        kclk = 1'b0;
        wait_cyc(FL - 1);
        kclk = 1'b1;
        wait_cyc(30);
        chk_eq("glitch oflag", 32'(n_of - of0), 32'h0);
        chk_eq("glitch perr", 32'(n_pe - pe0), 32'h0);
        chk_eq("glitch state", 32'(dut.state_q), 32'(ST_IDLE));
        frame_and_check("down", SC_DOWN, 1'b0, 1'b0);

        // Stalled frame: start + 4 data bits, then silence
        of0 = n_of;
        pe0 = n_pe;
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5);
        kdata = 1'b1;
        wait_cyc(TO + 10);
        chk_eq("timeout perr", 32'(n_pe - pe0), 32'h1);
        chk_eq("timeout oflag", 32'(n_of - of0), 32'h0);
        chk_eq("timeout state", 32'(dut.state_q), 32'(ST_IDLE));
        chk_eq("timeout keycode", 32'(keycode), 32'(exp_kc));
        frame_and_check("right", SC_RIGHT, 1'b0, 1'b0);

        // Reset in the middle of a frame
        of0 = n_of;
        pe0 = n_pe;
        send_bits(mk_frame(8'h3C, 1'b0, 1'b0), 5);
        reset = 1'b0;
        wait_cyc(3);
        chk_eq("midrst keycode", 32'(keycode), 32'h0);
        chk_eq("midrst state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b1;
        exp_kc = 16'h0000;
        wait_cyc(10);
        chk_eq("midrst perr", 32'(n_pe - pe0), 32'h0);
        chk_eq("midrst oflag", 32'(n_of - of0), 32'h0);
        frame_and_check("post-rst up", SC_UP, 1'b0, 1'b0);

        // Random frames with occasional parity/stop faults
        for (int k = 0; k < 16; k++) begin
            b = 8'($urandom);
            r = int'($urandom_range(0, 9));
            frame_and_check($sformatf("rand%0d", k), b, r == 0 || r == 2, r == 1 || r == 2);
        end

        wait_cyc(5);
        chk_eq("oflag/perr overlap", 32'(n_both), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
